// File: rtl/match_engine.sv
// rtl/match_engine.sv - parametrised card-matching engine for the Memory Game
// Optional feature macro: MATCH_ENGINE_MISS_CTR_EN (implements miss_ctr; otherwise tied to 0)
module match_engine #(
  parameter int MAX_CARDS   = 32,
  parameter int ADDR_W      = 5,
  parameter int COLOR_W     = 4,
  parameter int MATCH_SIZE  = 2,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int HOLD_W      = 26,
  parameter int CTR_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W:0]      num_of_cards,
  input  logic                 start,
  input  logic                 ld_valid,
  input  logic [ADDR_W-1:0]    ld_address,
  input  logic [COLOR_W-1:0]   ld_color,
  input  logic                 ld_done,
  input  logic                 click_valid,
  input  logic [ADDR_W-1:0]    click_address,
  output logic                 click_ready,
  input  logic [ADDR_W-1:0]    rd_address,
  output logic [COLOR_W+1:0]   rd_data,
  output logic                 update_cards,
  output logic                 busy,
  output logic                 game_done,
  output logic [CTR_W-1:0]     matched_groups_ctr,
  output logic [CTR_W-1:0]     moves_ctr,
  output logic [CTR_W-1:0]     miss_ctr
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PLAY    = 3'd2,
    S_HOLD    = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [1:0]        CS_HIDDEN   = 2'b00;
  localparam logic [1:0]        CS_REVEALED = 2'b01;
  localparam logic [1:0]        CS_MATCHED  = 2'b10;
  localparam logic [ADDR_W:0]   CARD_LIM    = MAX_CARDS[ADDR_W:0];
  localparam logic [ADDR_W:0]   GROUP_DIV   = MATCH_SIZE[ADDR_W:0];
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]        PICK_LAST   = 3'(MATCH_SIZE - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [COLOR_W-1:0]   r_color  [MAX_CARDS];
  logic [1:0]           r_cstate [MAX_CARDS];
  logic [ADDR_W:0]      r_num;
  logic [ADDR_W:0]      r_target;
  logic [ADDR_W-1:0]    r_pick   [MATCH_SIZE];
  logic [2:0]           r_pick_cnt;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [CTR_W-1:0]     r_matched;
  logic [CTR_W-1:0]     r_moves;
  logic [COLOR_W+1:0]   r_rd_data;
  logic                 r_update;

  logic                 w_click_hs;
  logic                 w_click_in_range;
  logic                 w_reveal;
  logic                 w_last_pick;
  logic                 w_ld_wr;
  logic                 w_hold_done;
  logic                 w_all_eq;
  logic                 w_in_compare;
  logic [CTR_W-1:0]     w_matched_inc;
  logic                 w_reach_target;

  // A click that lands while start is high is consumed but has no effect.
  assign w_click_hs       = click_valid & (r_state == S_PLAY);
  assign w_click_in_range = ({1'b0, click_address} < r_num) && ({1'b0, click_address} < CARD_LIM);
  assign w_reveal         = w_click_hs & ~start & w_click_in_range &
                            (r_cstate[click_address] == CS_HIDDEN);
  assign w_last_pick      = w_reveal & (r_pick_cnt == PICK_LAST);
  assign w_ld_wr          = (r_state == S_LOAD) & ~start & ld_valid &
                            ({1'b0, ld_address} < r_num) && ({1'b0, ld_address} < CARD_LIM);
  assign w_hold_done      = (r_hold_cnt == HOLD_LAST);
  assign w_in_compare     = (r_state == S_COMPARE);
  assign w_matched_inc    = (r_matched == '1) ? r_matched : r_matched + 1'b1;
  assign w_reach_target   = (32'(w_matched_inc) == 32'(r_target));

  // Group compare: every picked colour must equal the first pick's colour.
  always_comb begin
    w_all_eq = 1'b1;
    for (int i = 1; i < MATCH_SIZE; i++) begin
      if (r_color[r_pick[i]] != r_color[r_pick[0]]) w_all_eq = 1'b0;
    end
  end

  // Game state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state decode and status outputs; start overrides every state.
  always_comb begin
    w_next_state = r_state;
    click_ready  = 1'b0;
    busy         = 1'b0;
    game_done    = 1'b0;
    case (r_state)
      S_IDLE:    ;
      S_LOAD: begin
        busy = 1'b1;
        if (ld_done) w_next_state = (r_target == '0) ? S_DONE : S_PLAY;
      end
      S_PLAY: begin
        click_ready = 1'b1;
        if (w_last_pick) w_next_state = S_HOLD;
      end
      S_HOLD: begin
        busy = 1'b1;
        if (w_hold_done) w_next_state = S_COMPARE;
      end
      S_COMPARE: begin
        busy         = 1'b1;
        w_next_state = (w_all_eq && w_reach_target) ? S_DONE : S_PLAY;
      end
      S_DONE:    game_done = 1'b1;
      default:   w_next_state = S_IDLE;
    endcase
    if (start) w_next_state = S_LOAD;
  end

  // Card store: colour loads, reveals, and the compare verdict on the picked group.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_CARDS; i++) begin
        r_color[i]  <= '0;
        r_cstate[i] <= CS_HIDDEN;
      end
    end else if (start) begin
      for (int i = 0; i < MAX_CARDS; i++) r_cstate[i] <= CS_HIDDEN;
    end else begin
      if (w_ld_wr)  r_color[ld_address]     <= ld_color;
      if (w_reveal) r_cstate[click_address] <= CS_REVEALED;
      if (w_in_compare) begin
        for (int i = 0; i < MATCH_SIZE; i++)
          r_cstate[r_pick[i]] <= w_all_eq ? CS_MATCHED : CS_HIDDEN;
      end
    end
  end

  // Game setup latch: active card count and number of groups needed to win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_num    <= '0;
      r_target <= '0;
    end else if (start) begin
      r_num    <= num_of_cards;
      r_target <= num_of_cards / GROUP_DIV;
    end
  end

  // Pick list and pick count; cleared by start and after each compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pick_cnt <= '0;
      for (int i = 0; i < MATCH_SIZE; i++) r_pick[i] <= '0;
    end else if (start) begin
      r_pick_cnt <= '0;
      for (int i = 0; i < MATCH_SIZE; i++) r_pick[i] <= '0;
    end else if (w_in_compare) begin
      r_pick_cnt <= '0;
    end else if (w_reveal) begin
      r_pick_cnt <= r_pick_cnt + 1'b1;
      for (int i = 0; i < MATCH_SIZE; i++)
        if (r_pick_cnt == 3'(i)) r_pick[i] <= click_address;
    end
  end

  // Reveal hold timer; runs only while in HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_hold_cnt <= '0;
    else if (r_state == S_HOLD && !w_hold_done) r_hold_cnt <= r_hold_cnt + 1'b1;
    else                                        r_hold_cnt <= '0;
  end

  // Saturating matched-group and move counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_matched <= '0;
      r_moves   <= '0;
    end else if (start) begin
      r_matched <= '0;
      r_moves   <= '0;
    end else begin
      if (w_in_compare && w_all_eq)      r_matched <= w_matched_inc;
      if (w_last_pick && r_moves != '1)  r_moves   <= r_moves + 1'b1;
    end
  end

`ifdef MATCH_ENGINE_MISS_CTR_EN
  logic [CTR_W-1:0] r_miss;

  // Saturating miss counter for failed group attempts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          r_miss <= '0;
    else if (start)                                    r_miss <= '0;
    else if (w_in_compare && !w_all_eq && r_miss != '1) r_miss <= r_miss + 1'b1;
  end

  assign miss_ctr = r_miss;
`else
  assign miss_ctr = '0;
`endif

  // Renderer read port (one-cycle latency) and board-change pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
      r_update  <= 1'b0;
    end else begin
      r_rd_data <= ({1'b0, rd_address} < CARD_LIM) ?
                   {r_color[rd_address], r_cstate[rd_address]} : '0;
      r_update  <= start | w_ld_wr | w_reveal | w_in_compare;
    end
  end

  assign rd_data            = r_rd_data;
  assign update_cards       = r_update;
  assign matched_groups_ctr = r_matched;
  assign moves_ctr          = r_moves;

endmodule

// File: tb/tb_match_engine.sv
// tb/tb_match_engine.sv - self-checking bench for match_engine (pair and triple builds)
module tb_match_engine;

  localparam int HOLD = 4;
`ifdef MATCH_ENGINE_MISS_CTR_EN
  localparam int MISS1 = 1;
`else
  localparam int MISS1 = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] num_of_cards = '0;
  logic       start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [4:0] ld_address = '0;
  logic [3:0] ld_color = '0;
  logic       ld_done = 1'b0;
  logic       click_valid = 1'b0;
  logic [4:0] click_address = '0;
  logic [4:0] rd_address = '0;

  logic       a_ready, a_upd, a_busy, a_done;
  logic [5:0] a_rd;
  logic [7:0] a_matched, a_moves, a_miss;
  logic       b_ready, b_upd, b_busy, b_done;
  logic [5:0] b_rd;
  logic [7:0] b_matched, b_moves, b_miss;

  match_engine #(.MATCH_SIZE(2), .HOLD_CYCLES(HOLD)) u_pair (
    .clk(clk), .rst(rst), .num_of_cards(num_of_cards), .start(start),
    .ld_valid(ld_valid), .ld_address(ld_address), .ld_color(ld_color), .ld_done(ld_done),
    .click_valid(click_valid), .click_address(click_address), .click_ready(a_ready),
    .rd_address(rd_address), .rd_data(a_rd), .update_cards(a_upd), .busy(a_busy),
    .game_done(a_done), .matched_groups_ctr(a_matched), .moves_ctr(a_moves), .miss_ctr(a_miss)
  );

  match_engine #(.MATCH_SIZE(3), .HOLD_CYCLES(HOLD)) u_triple (
    .clk(clk), .rst(rst), .num_of_cards(num_of_cards), .start(start),
    .ld_valid(ld_valid), .ld_address(ld_address), .ld_color(ld_color), .ld_done(ld_done),
    .click_valid(click_valid), .click_address(click_address), .click_ready(b_ready),
    .rd_address(rd_address), .rd_data(b_rd), .update_cards(b_upd), .busy(b_busy),
    .game_done(b_done), .matched_groups_ctr(b_matched), .moves_ctr(b_moves), .miss_ctr(b_miss)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] addr;
    logic       exp_upd;
    logic [5:0] exp_rd;
  } vec_t;

  vec_t tbl[4];
  vec_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    num_of_cards = 6'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Loads n colours (nibble i = card i), plus one out-of-range write to card 30.
  task automatic do_load(input int n, input logic [31:0] cols);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_address = 5'(i);
      ld_color = cols[i*4 +: 4];
    end
    @(negedge clk);
    ld_address = 5'd30;
    ld_color = 4'hf;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
  endtask

  task automatic click(input bit sel3, input int a, output logic upd);
    @(negedge clk);
    click_valid = 1'b1;
    click_address = 5'(a);
    rd_address = 5'(a);
    @(negedge clk);
    click_valid = 1'b0;
    upd = sel3 ? b_upd : a_upd;
  endtask

  task automatic read_card(input bit sel3, input int a, output int d);
    @(negedge clk);
    rd_address = 5'(a);
    @(negedge clk);
    d = sel3 ? int'(b_rd) : int'(a_rd);
  endtask

  function automatic bit cond_f(input bit sel3, input bit want_done);
    if (want_done) return sel3 ? b_done : a_done;
    return sel3 ? b_ready : a_ready;
  endfunction

  // Called right after the final pick; counts cycles until PLAY (or DONE) reappears.
  task automatic wait_for(input bit sel3, input bit want_done, input string name);
    int n = 0;
    while (!cond_f(sel3, want_done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, HOLD + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic upd;
    int   d;
    vec_t e;

    tbl[0] = '{addr: 5'd7,  exp_upd: 1'b0, exp_rd: 6'd0};
    tbl[1] = '{addr: 5'd0,  exp_upd: 1'b1, exp_rd: 6'd5};
    tbl[2] = '{addr: 5'd0,  exp_upd: 1'b0, exp_rd: 6'd5};
    tbl[3] = '{addr: 5'd31, exp_upd: 1'b0, exp_rd: 6'd0};

    repeat (3) @(negedge clk);
    chk("rst_ready", a_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_matched", a_matched, 0);
    chk("rst_moves", a_moves, 0);
    chk("rst_miss", a_miss, 0);
    chk("rst_upd", a_upd, 0);
    chk("rst_rd", a_rd, 0);
    chk("rst_ready3", b_ready, 0);
    @(negedge clk);
    rst = 1'b1;

    // Pair game, colours {1,2,1,2}
    do_start(4);
    chk("load_busy", a_busy, 1);
    chk("load_ready", a_ready, 0);
    do_load(4, 32'h0000_2121);
    chk("play_ready", a_ready, 1);
    chk("play_busy", a_busy, 0);

    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(tbl[i]);
      click(1'b0, int'(tbl[i].addr), upd);
      read_card(1'b0, int'(tbl[i].addr), d);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_upd", i), upd, e.exp_upd);
      chk($sformatf("vec%0d_rd", i), d, e.exp_rd);
    end

    click(1'b0, 1, upd);
    chk("miss_pick_upd", upd, 1);
    chk("hold_busy", a_busy, 1);
    chk("hold_ready", a_ready, 0);
    wait_for(1'b0, 1'b0, "miss_hold_len");
    chk("miss_cmp_upd", a_upd, 1);
    read_card(1'b0, 0, d);
    chk("miss_card0", d, 4);
    read_card(1'b0, 1, d);
    chk("miss_card1", d, 8);
    chk("miss_ctr", a_miss, MISS1);
    chk("miss_moves", a_moves, 1);
    chk("miss_matched", a_matched, 0);

    click(1'b0, 0, upd);
    click(1'b0, 2, upd);
    wait_for(1'b0, 1'b0, "match_hold_len");
    read_card(1'b0, 0, d);
    chk("match_card0", d, 6);
    read_card(1'b0, 2, d);
    chk("match_card2", d, 6);
    chk("match_matched", a_matched, 1);
    chk("match_moves", a_moves, 2);
    read_card(1'b0, 30, d);
    chk("dropped_write", d, 0);

    click(1'b0, 1, upd);
    click(1'b0, 3, upd);
    wait_for(1'b0, 1'b1, "final_hold_len");
    chk("done_flag", a_done, 1);
    chk("done_ready", a_ready, 0);
    chk("done_matched", a_matched, 2);
    chk("done_moves", a_moves, 3);

    // start colliding with a click during PLAY
    do_start(4);
    do_load(4, 32'h0000_2121);
    click(1'b0, 0, upd);
    click(1'b0, 1, upd);
    wait_for(1'b0, 1'b0, "g2_hold_len");
    click(1'b0, 0, upd);
    @(negedge clk);
    start = 1'b1;
    num_of_cards = 6'd4;
    click_valid = 1'b1;
    click_address = 5'd1;
    @(negedge clk);
    start = 1'b0;
    click_valid = 1'b0;
    chk("sc_busy", a_busy, 1);
    chk("sc_ready", a_ready, 0);
    chk("sc_moves", a_moves, 0);
    chk("sc_miss", a_miss, 0);
    chk("sc_matched", a_matched, 0);
    read_card(1'b0, 0, d);
    chk("sc_card0", d, 4);
    read_card(1'b0, 1, d);
    chk("sc_card1", d, 8);

    // Triple game, colours {3,3,3,5,5,5,9}; card 6 is a leftover
    do_start(7);
    do_load(7, 32'h0955_5333);
    click(1'b1, 0, upd);
    chk("tri_upd", upd, 1);
    click(1'b1, 1, upd);
    click(1'b1, 2, upd);
    wait_for(1'b1, 1'b0, "tri_hold_len");
    chk("tri_matched1", b_matched, 1);
    click(1'b1, 3, upd);
    click(1'b1, 4, upd);
    click(1'b1, 5, upd);
    wait_for(1'b1, 1'b1, "tri_done_wait");
    chk("tri_done", b_done, 1);
    chk("tri_matched2", b_matched, 2);
    chk("tri_moves", b_moves, 2);
    chk("tri_miss", b_miss, 0);
    chk("tri_ready", b_ready, 0);
    read_card(1'b1, 6, d);
    chk("tri_leftover", d, 36);

    // Reset during HOLD, then a zero-target game
    do_start(4);
    do_load(4, 32'h0000_2121);
    click(1'b0, 0, upd);
    click(1'b0, 2, upd);
    chk("pre_rst_busy", a_busy, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_ready", a_ready, 0);
    chk("mid_rst_done", a_done, 0);
    chk("mid_rst_moves", a_moves, 0);
    chk("mid_rst_matched", a_matched, 0);
    chk("mid_rst_upd", a_upd, 0);
    chk("mid_rst_rd", a_rd, 0);
    @(negedge clk);
    rst = 1'b1;
    read_card(1'b0, 0, d);
    chk("post_rst_card0", d, 0);
    read_card(1'b0, 2, d);
    chk("post_rst_card2", d, 0);
    do_start(1);
    @(negedge clk);
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    chk("zero_target_done", a_done, 1);
    chk("zero_target_busy", a_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
